vecmac_job_ctrl: RTL and testbench

//  Sequences long int8 dot products on the 16-lane mul16x8x8_wallace MAC.

---
 rtl/vecmac_job_ctrl_if.sv | 34 +++
 rtl/vecmac_job_ctrl.sv | 97 +++++++++
 tb/tb_vecmac_job_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vecmac_job_ctrl_if.sv
// Job control, operand stream, MAC link and result port of vecmac_job_ctrl.
// The controller attaches through the slave modport; the job owner/MAC side uses master.
interface vecmac_job_ctrl_if #(
  parameter int LEN_W = 12,
  parameter int ACC_W = 32
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             op_valid;
  logic             op_ready;
  logic [127:0]     op_a;
  logic [127:0]     op_b;
  logic             mac_in_valid;
  logic [127:0]     mac_in_a;
  logic [127:0]     mac_in_b;
  logic             mac_out_valid;
  logic [19:0]      mac_out_sum;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             err_stray;

  modport master (
    output start, len, abort, op_valid, op_a, op_b, mac_out_valid, mac_out_sum, res_ready,
    input  busy, op_ready, mac_in_valid, mac_in_a, mac_in_b, res_valid, res_data, err_stray
  );

  modport slave (
    input  start, len, abort, op_valid, op_a, op_b, mac_out_valid, mac_out_sum, res_ready,
    output busy, op_ready, mac_in_valid, mac_in_a, mac_in_b, res_valid, res_data, err_stray
  );
endinterface

// File: rtl/vecmac_job_ctrl.sv
// Sequences a multi-beat int8 dot product through the 16-lane MAC and returns
// one accumulated result per job; abort flushes in-flight MAC beats.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | accepting operand beats and issuing them to the MAC
// DRAIN  | all beats issued, collecting remaining MAC returns
// RESULT | res_valid high, holding acc until res_ready
// FLUSH  | aborted, discarding returns until nothing is outstanding
module vecmac_job_ctrl #(
  parameter int LEN_W = 12,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  vecmac_job_ctrl_if.slave   bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] RESULT = 3'd3;
  localparam logic [2:0] FLUSH  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [LEN_W-1:0] len_q, issue_cnt, ret_cnt, outstanding;
  logic [ACC_W-1:0] acc;
  logic             fire, ret, stray, accum, last_issue, last_ret;

  assign fire       = bus.op_valid && (state == ISSUE);
  assign ret        = bus.mac_out_valid && (outstanding != '0);
  assign stray      = bus.mac_out_valid && (outstanding == '0);
  // returns arriving during FLUSH belong to a cancelled job and are dropped
  assign accum      = ret && ((state == ISSUE) || (state == DRAIN));
  assign last_issue = fire && (issue_cnt == len_q - LEN_W'(1));
  assign last_ret   = accum && (ret_cnt == len_q - LEN_W'(1));

  assign bus.op_ready  = (state == ISSUE);
  assign bus.busy      = (state != IDLE);
  assign bus.res_valid = (state == RESULT);
  assign bus.res_data  = acc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.len != '0) ? ISSUE : RESULT;
      ISSUE:   if (bus.abort) state_nxt = FLUSH;
               else if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (bus.abort) state_nxt = FLUSH;
               else if (last_ret) state_nxt = RESULT;
      RESULT:  if (bus.abort || bus.res_ready) state_nxt = IDLE;
      FLUSH:   if (outstanding == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      len_q            <= '0;
      issue_cnt        <= '0;
      ret_cnt          <= '0;
      outstanding      <= '0;
      acc              <= '0;
      bus.mac_in_valid <= 1'b0;
      bus.mac_in_a     <= '0;
      bus.mac_in_b     <= '0;
      bus.err_stray    <= 1'b0;
    end else begin
      state            <= state_nxt;
      bus.mac_in_valid <= fire;
      if (fire) begin
        bus.mac_in_a <= bus.op_a;
        bus.mac_in_b <= bus.op_b;
      end
      if (stray) bus.err_stray <= 1'b1;

      if ((state == IDLE) && bus.start) begin
        len_q     <= bus.len;
        acc       <= '0;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (fire) issue_cnt <= issue_cnt + LEN_W'(1);
        if (accum) begin
          acc     <= acc + {{(ACC_W-20){1'b0}}, bus.mac_out_sum};
          ret_cnt <= ret_cnt + LEN_W'(1);
        end
      end

      case ({fire, ret})
        2'b10:   outstanding <= outstanding + LEN_W'(1);
        2'b01:   outstanding <= outstanding - LEN_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_vecmac_job_ctrl.sv
// Randomized scoreboard bench for vecmac_job_ctrl with a fixed-latency MAC model.
module tb_vecmac_job_ctrl;
  localparam int LEN_W = 12;
  localparam int ACC_W = 32;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vecmac_job_ctrl_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus();
  vecmac_job_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] sb_q[$];
  logic stray_inj = 1'b0;
  logic pipe_v [LAT];
  logic [19:0] pipe_s [LAT];
  int pulses_total = 0;

  function automatic logic [19:0] lanesum(input logic [127:0] a, input logic [127:0] b);
    logic [19:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s += 20'(a[8*i +: 8]) * 20'(b[8*i +: 8]);
    return s;
  endfunction

  // MAC model: dot product of the 16 lanes, LAT cycles later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_s[i] <= '0;
      end
    end else begin
      pipe_v[0] <= bus.mac_in_valid;
      pipe_s[0] <= lanesum(bus.mac_in_a, bus.mac_in_b);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_s[i] <= pipe_s[i-1];
      end
    end
  end
  assign bus.mac_out_valid = pipe_v[LAT-1] | stray_inj;
  assign bus.mac_out_sum   = stray_inj ? 20'hABCDE : pipe_s[LAT-1];

  always @(posedge clk) if (bus.mac_in_valid === 1'b1) pulses_total <= pulses_total + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (sb_q.size() == 0) fail("res_unexpected", bus.res_data, 0);
      else chk("res_data", bus.res_data, sb_q.pop_front());
    end
  end

  task automatic wait_idle(input int budget);
    int g = 0;
    while (bus.busy !== 1'b0 && g < budget) begin
      @(posedge clk); #1;
      g++;
    end
    if (bus.busy !== 1'b0) fail("idle_timeout", bus.busy, 0);
  endtask

  task automatic start_pulse(input int n);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // pat: 0 random, 1 all 8'hFF, 2 all 8'h01, 3 all 8'h02
  task automatic run_job(input int n, input int pat, input int abort_after,
                         input bit bubbles, input bit drain_chk, input bit wait_done);
    logic [127:0] qa[$], qb[$];
    logic [127:0] a, b;
    longint tot = 0;
    int base, issued, g;
    bit fired;
    for (int i = 0; i < n; i++) begin
      case (pat)
        1: begin a = {16{8'hFF}}; b = {16{8'hFF}}; end
        2: begin a = {16{8'h01}}; b = {16{8'h01}}; end
        3: begin a = {16{8'h02}}; b = {16{8'h02}}; end
        default: begin
          a = {$urandom, $urandom, $urandom, $urandom};
          b = {$urandom, $urandom, $urandom, $urandom};
        end
      endcase
      qa.push_back(a);
      qb.push_back(b);
      tot += longint'(lanesum(a, b));
    end
    base = pulses_total;
    if (abort_after < 0) sb_q.push_back(ACC_W'(tot));
    start_pulse(n);
    issued = 0;
    for (int i = 0; i < n; i++) begin
      if (abort_after >= 0 && issued == abort_after) break;
      if (bubbles && $urandom_range(0, 2) == 0) begin
        bus.op_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      bus.op_valid = 1'b1;
      bus.op_a = qa[i];
      bus.op_b = qb[i];
      fired = 1'b0;
      g = 0;
      while (!fired) begin
        @(negedge clk);
        fired = bus.op_ready;
        @(posedge clk); #1;
        g++;
        if (!fired && g > 100) begin
          fail("op_ready_timeout", 0, 1);
          fired = 1'b1;
        end
      end
      issued++;
    end
    bus.op_valid = 1'b0;
    if (abort_after >= 0) begin
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      @(negedge clk);
      chk("flush_busy", bus.busy, 1);
      chk("flush_op_ready", bus.op_ready, 0);
    end else if (drain_chk) begin
      @(negedge clk);
      chk("op_ready_after_last", bus.op_ready, 0);
    end
    if (wait_done) begin
      wait_idle(n * 4 + 100);
      chk("mac_pulses", pulses_total - base, (abort_after >= 0) ? issued : n);
    end
  endtask

  task automatic watch_consec(input int n);
    int g = 0;
    int run = 0;
    @(negedge clk);
    while (bus.mac_in_valid !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    while (bus.mac_in_valid === 1'b1 && run < 20) begin
      run++;
      @(negedge clk);
    end
    chk("consec_pulses", run, n);
  endtask

  initial begin
    int base, n, ab, g;
    bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.res_ready = 1'b1;

    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_op_ready", bus.op_ready, 0);
    chk("rst_mac_in_valid", bus.mac_in_valid, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_err_stray", bus.err_stray, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // single full-scale beat
    run_job(1, 1, -1, 1'b0, 1'b1, 1'b1);

    // back-to-back beats with op_valid held
    fork
      run_job(4, 2, -1, 1'b0, 1'b1, 1'b1);
      watch_consec(4);
    join

    // zero-length job, and start while busy is ignored
    base = pulses_total;
    bus.res_ready = 1'b0;
    sb_q.push_back('0);
    start_pulse(0);
    @(negedge clk);
    chk("len0_res_valid", bus.res_valid, 1);
    @(posedge clk); #1;
    start_pulse(3);
    @(negedge clk);
    chk("len0_hold_valid", bus.res_valid, 1);
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("len0_idle", bus.busy, 0);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("start_ignored_busy", bus.busy, 0);
    chk("len0_pulses", pulses_total - base, 0);
    @(posedge clk); #1;

    // result held under res_ready backpressure
    bus.res_ready = 1'b0;
    run_job(2, 0, -1, 1'b1, 1'b0, 1'b0);
    g = 0;
    @(negedge clk);
    while (bus.res_valid !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    for (int i = 0; i < 10; i++) begin
      chk("hold_res_valid", bus.res_valid, 1);
      chk("hold_res_data", bus.res_data, (sb_q.size() != 0) ? sb_q[0] : '0);
      chk("hold_busy", bus.busy, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_idle", bus.busy, 0);
    @(posedge clk); #1;

    // abort with beats in flight, then a clean job
    run_job(8, 0, 3, 1'b0, 1'b0, 1'b1);
    run_job(1, 3, -1, 1'b0, 1'b1, 1'b1);

    // random jobs, some aborted
    repeat (12) begin
      n  = $urandom_range(1, 24);
      ab = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
      run_job(n, 0, ab, 1'b1, 1'b0, 1'b1);
    end

    // stray MAC return is ignored for acc but flagged sticky
    stray_inj = 1'b1;
    @(posedge clk); #1;
    stray_inj = 1'b0;
    @(negedge clk);
    chk("stray_set", bus.err_stray, 1);
    @(posedge clk); #1;
    run_job(3, 0, -1, 1'b1, 1'b0, 1'b1);
    chk("stray_sticky", bus.err_stray, 1);

    // maximum-length job
    run_job(4095, 1, -1, 1'b0, 1'b1, 1'b1);

    // asynchronous reset in the middle of ISSUE
    start_pulse(10);
    bus.op_valid = 1'b1;
    bus.op_a = {16{8'h03}};
    bus.op_b = {16{8'h05}};
    repeat (6) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_op_ready", bus.op_ready, 0);
    chk("arst_mac_in_valid", bus.mac_in_valid, 0);
    chk("arst_mac_in_a", bus.mac_in_a, 0);
    chk("arst_res_valid", bus.res_valid, 0);
    chk("arst_res_data", bus.res_data, 0);
    chk("arst_err_stray", bus.err_stray, 0);
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("post_rst_err_stray", bus.err_stray, 0);
    chk("post_rst_busy", bus.busy, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
